// File: rtl/clk_period_meter_if.sv
// Bundles the measurement request, the signal under test and the result/status of the period meter.
interface clk_period_meter_if #(
    parameter int unsigned CNT_W = 32
);
    logic             sig_in;
    logic             start;
    logic             busy;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             timeout;

    // Requester side: supplies the signal and the start pulse, reads back results.
    modport master (
        output sig_in, start,
        input  busy, period, high_time, valid, timeout
    );

    // Meter side.
    modport slave (
        input  sig_in, start,
        output busy, period, high_time, valid, timeout
    );
endinterface

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous signal in clk cycles.
module clk_period_meter #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned TIMEOUT    = 10000000,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    clk_period_meter_if.slave  bus
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic             s_meta, s, s_d;
    logic             rise_p;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] hi_cnt, hi_n;
    logic [CNT_W-1:0] tmo_cnt, tmo_n;
    logic [CNT_W-1:0] period_q, period_n;
    logic [CNT_W-1:0] high_q, high_n;
    logic             valid_q, valid_n;
    logic             tmo_q, tmo_pulse_n;
    logic             busy_q, busy_n;

    // Two-flop synchronizer plus one delay stage for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_meta <= 1'b0;
            s      <= 1'b0;
            s_d    <= 1'b0;
        end else begin
            s_meta <= bus.sig_in;
            s      <= s_meta;
            s_d    <= s;
        end
    end

    assign rise_p = s & ~s_d;

    // State and datapath registers; reset discards any partial measurement.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            hi_cnt   <= '0;
            tmo_cnt  <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            hi_cnt   <= hi_n;
            tmo_cnt  <= tmo_n;
            period_q <= period_n;
            high_q   <= high_n;
            valid_q  <= valid_n;
            tmo_q    <= tmo_pulse_n;
            busy_q   <= busy_n;
        end
    end

    // Next-state and counter logic; an edge on the terminal timeout cycle wins over the abort.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        hi_n        = hi_cnt;
        tmo_n       = tmo_cnt;
        period_n    = period_q;
        high_n      = high_q;
        valid_n     = 1'b0;
        tmo_pulse_n = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = ARM;
                    tmo_n   = '0;
                end
            end
            ARM: begin
                if (rise_p) begin
                    state_n = MEASURE;
                    cnt_n   = CNT_ONE;
                    hi_n    = CNT_ONE;
                    tmo_n   = '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n     = IDLE;
                    tmo_pulse_n = 1'b1;
                end else begin
                    tmo_n = tmo_cnt + CNT_ONE;
                end
            end
            MEASURE: begin
                if (rise_p) begin
                    period_n = cnt;
                    high_n   = hi_cnt;
                    valid_n  = 1'b1;
                    if (CONTINUOUS) begin
                        cnt_n = CNT_ONE;
                        hi_n  = CNT_ONE;
                        tmo_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n     = IDLE;
                    tmo_pulse_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                    hi_n  = hi_cnt + CNT_W'(s);
                    tmo_n = tmo_cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == ARM) || (state_n == MEASURE);
    end

    // Registered results and status.
    assign bus.busy      = busy_q;
    assign bus.period    = period_q;
    assign bus.high_time = high_q;
    assign bus.valid     = valid_q;
    assign bus.timeout   = tmo_q;

endmodule
